bp_stream_pump_out: RTL and testbench

- Transmit-side counterpart of the BedRock memory stream input pump.
- An FSM (CCE, cache engine, I/O adapter) presents one base header plus per-beat data. The pump serializes these into a BedRock xce mem stream: header, one data beat and a last flag per transfer.
- It drives the FSM with the wrap-around address of the beat currently being produced, so the FSM fetches data in critical-word-first order.
- It sits between message-producing FSMs and the stream bus / wormhole adapters.

---
 rtl/bp_stream_pump_out_pkg.sv | 49 ++++
 rtl/bp_stream_pump_out_if.sv | 35 +++
 rtl/bp_stream_pump_out_counter.sv | 95 +++++++++
 rtl/bp_stream_pump_out.sv | 82 ++++++++
 tb/tb_bp_stream_pump_out.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_stream_pump_out_pkg.sv
// Shared types for the BedRock mem stream pumps: header layout, message enums and the
// beat-count helper constants.
package bp_stream_pump_out_pkg;

  localparam int unsigned paddr_width_gp     = 40;
  localparam int unsigned dword_width_gp     = 64;
  localparam int unsigned cce_block_width_gp = 512;
  localparam int unsigned lce_id_width_gp    = 8;

  typedef enum logic [3:0] {
    e_rd_msg    = 4'd0,
    e_wr_msg    = 4'd1,
    e_uc_rd_msg = 4'd2,
    e_uc_wr_msg = 4'd3,
    e_pre_msg   = 4'd4,
    e_amo_msg   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_size_1   = 3'd0,
    e_size_2   = 3'd1,
    e_size_4   = 3'd2,
    e_size_8   = 3'd3,
    e_size_16  = 3'd4,
    e_size_32  = 3'd5,
    e_size_64  = 3'd6,
    e_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    bp_bedrock_mem_type_e        msg_type;
    bp_bedrock_msg_size_e        size;
    logic [lce_id_width_gp-1:0]  lce_id;
    logic [paddr_width_gp-1:0]   addr;
  } bp_bedrock_mem_header_s;

  localparam int unsigned mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

  // Bit n set means msg_type n carries a multi-beat payload.
  localparam logic [15:0] default_payload_mask_gp =
    (16'(1) << e_wr_msg) | (16'(1) << e_uc_wr_msg);

  typedef enum logic [0:0] {StIdle, StStream} pump_state_e;

  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bp_stream_pump_out_if.sv
// FSM-side and bus-side signals of the output pump. The master modport is the pump's view,
// the slave modport is the view of the FSM/bus environment around it.
interface bp_stream_pump_out_if
  import bp_stream_pump_out_pkg::*;
#(
  parameter int unsigned stream_data_width_p = dword_width_gp
);

  bp_bedrock_mem_header_s          fsm_base_header;
  logic [stream_data_width_p-1:0]  fsm_data;
  logic                            fsm_v;
  logic                            fsm_ready_and;
  logic [paddr_width_gp-1:0]       fsm_addr;
  logic                            fsm_new;
  logic                            fsm_done;

  bp_bedrock_mem_header_s          mem_header;
  logic [stream_data_width_p-1:0]  mem_data;
  logic                            mem_v;
  logic                            mem_last;
  logic                            mem_ready_and;

  modport master (
    input  fsm_base_header, fsm_data, fsm_v, mem_ready_and,
    output fsm_ready_and, fsm_addr, fsm_new, fsm_done,
    output mem_header, mem_data, mem_v, mem_last
  );

  modport slave (
    output fsm_base_header, fsm_data, fsm_v, mem_ready_and,
    input  fsm_ready_and, fsm_addr, fsm_new, fsm_done,
    input  mem_header, mem_data, mem_v, mem_last
  );

endinterface

// File: rtl/bp_stream_pump_out_counter.sv
// IDLE/STREAM tracker, beat counter and critical-word-first wrap-address mux for a stream pump.
module bp_stream_pump_out_counter
  import bp_stream_pump_out_pkg::*;
#(
  parameter int unsigned stream_data_width_p = dword_width_gp,
  parameter int unsigned block_width_p       = cce_block_width_gp,
  parameter logic [15:0] payload_mask_p      = default_payload_mask_gp
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  bp_bedrock_mem_header_s     header_i,
  input  logic                       fire_i,
  output logic                       stream_o,
  output logic [paddr_width_gp-1:0]  addr_o,
  output logic                       first_o,
  output logic                       last_o
);

  localparam int unsigned stream_words_lp        = block_width_p / stream_data_width_p;
  localparam int unsigned data_len_width_lp      = safe_clog2(stream_words_lp);
  localparam int unsigned stream_offset_width_lp = safe_clog2(stream_data_width_p >> 3);

  if (stream_words_lp == 1) begin : g_single
    logic unused;
    assign unused   = ^{clk_i, reset_i, fire_i, header_i};
    assign stream_o = 1'b0;
    assign addr_o   = header_i.addr;
    assign first_o  = 1'b1;
    assign last_o   = 1'b1;
  end else begin : g_multi
    typedef logic [data_len_width_lp-1:0] cnt_t;

    pump_state_e state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [31:0] beats_wide;
    cnt_t        num_beats, first_cnt, last_cnt, mask, cur_cnt;
    logic        is_stream;
    logic        unused;

    assign unused = ^header_i.lce_id;

    // is_stream uses the untruncated count; a block-size message truncates to 0, which makes
    // mask all ones and last_cnt = first_cnt - 1, i.e. the full counter range.
    always_comb begin
      beats_wide = (32'd1 << header_i.size) >> stream_offset_width_lp;
      if (beats_wide == 32'd0) beats_wide = 32'd1;
      num_beats = beats_wide[data_len_width_lp-1:0];
      is_stream = payload_mask_p[header_i.msg_type] & (beats_wide > 32'd1);
      first_cnt = header_i.addr[stream_offset_width_lp +: data_len_width_lp];
      mask      = num_beats - cnt_t'(1);
      last_cnt  = first_cnt + mask;
      cur_cnt   = (state_q == StStream) ? cnt_q : first_cnt;

      addr_o = header_i.addr;
      addr_o[stream_offset_width_lp +: data_len_width_lp] = (first_cnt & ~mask) | (cur_cnt & mask);
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      first_o = 1'b0;
      last_o  = 1'b0;
      case (state_q)
        StStream: begin
          last_o = (cnt_q == last_cnt);
          if (fire_i) begin
            cnt_d = cnt_q + cnt_t'(1);
            if (last_o) state_d = StIdle;
          end
        end
        default: begin
          first_o = 1'b1;
          last_o  = ~is_stream;
          if (fire_i && is_stream) begin
            state_d = StStream;
            cnt_d   = first_cnt + cnt_t'(1);
          end
        end
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign stream_o = (state_q == StStream);
  end

endmodule

// File: rtl/bp_stream_pump_out.sv
// BedRock mem stream output pump: serializes header + per-beat FSM data into a stream with a
// last flag, buffered by a two-entry FIFO (1-cycle latency, full throughput).
module bp_stream_pump_out
  import bp_stream_pump_out_pkg::*;
#(
  parameter int unsigned stream_data_width_p = dword_width_gp,
  parameter int unsigned block_width_p       = cce_block_width_gp,
  parameter logic [15:0] payload_mask_p      = default_payload_mask_gp
) (
  input logic                 clk_i,
  input logic                 reset_i,
  bp_stream_pump_out_if.master pump_io
);

  typedef struct packed {
    logic                            last;
    bp_bedrock_mem_header_s          header;
    logic [stream_data_width_p-1:0]  data;
  } entry_t;

  entry_t                 slot_q [2];
  entry_t                 head;
  logic                   wptr_q, rptr_q;
  logic [1:0]             count_q, count_d;
  logic                   fire, deq;
  logic                   streaming, beat_first, beat_last;
  bp_bedrock_mem_header_s header_q, header_eff;

  assign pump_io.fsm_ready_and = (count_q != 2'd2) & ~reset_i;
  assign fire = pump_io.fsm_v & pump_io.fsm_ready_and;
  assign deq  = pump_io.mem_v & pump_io.mem_ready_and;

  // Mid-message the live header input is don't-care; the latched copy carries the message.
  assign header_eff = streaming ? header_q : pump_io.fsm_base_header;

  bp_stream_pump_out_counter #(
    .stream_data_width_p(stream_data_width_p),
    .block_width_p      (block_width_p),
    .payload_mask_p     (payload_mask_p)
  ) u_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .header_i(header_eff),
    .fire_i  (fire),
    .stream_o(streaming),
    .addr_o  (pump_io.fsm_addr),
    .first_o (beat_first),
    .last_o  (beat_last)
  );

  assign pump_io.fsm_new  = pump_io.fsm_v & beat_first;
  assign pump_io.fsm_done = fire & beat_last;

  always_comb begin
    count_d = count_q + 2'(fire) - 2'(deq);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_q ^ fire;
      rptr_q  <= rptr_q ^ deq;
    end
  end

  // Storage needs no reset: fire is blocked during reset and mem_v gates the outputs.
  always_ff @(posedge clk_i) begin
    if (fire) slot_q[wptr_q] <= '{last: beat_last, header: header_eff, data: pump_io.fsm_data};
    if (fire && !streaming) header_q <= pump_io.fsm_base_header;
  end

  assign head               = slot_q[rptr_q];
  assign pump_io.mem_v      = (count_q != 2'd0);
  assign pump_io.mem_header = head.header;
  assign pump_io.mem_data   = head.data;
  assign pump_io.mem_last   = pump_io.mem_v & head.last;

endmodule

// File: tb/tb_bp_stream_pump_out.sv
// Directed bench for bp_stream_pump_out: block 512, beat 64, write types carry payload.
module tb_bp_stream_pump_out;
  import bp_stream_pump_out_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  typedef struct packed {
    logic                   last;
    bp_bedrock_mem_header_s header;
    logic [63:0]            data;
  } cap_t;

  cap_t cap_q [$];

  bp_stream_pump_out_if #(.stream_data_width_p(64)) bus ();

  bp_stream_pump_out #(
    .stream_data_width_p(64),
    .block_width_p      (512),
    .payload_mask_p     (default_payload_mask_gp)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .pump_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && bus.mem_v && bus.mem_ready_and)
      cap_q.push_back('{last: bus.mem_last, header: bus.mem_header, data: bus.mem_data});
  end

  function automatic bp_bedrock_mem_header_s mk_hdr(input bp_bedrock_mem_type_e t,
                                                     input bp_bedrock_msg_size_e s,
                                                     input logic [39:0] a);
    bp_bedrock_mem_header_s h;
    h.msg_type = t;
    h.size     = s;
    h.lce_id   = 8'h5a;
    h.addr     = a;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the beat.
  task automatic send(input string tag, input bp_bedrock_mem_header_s hdr,
                      input logic [63:0] data, input logic [39:0] exp_addr,
                      input logic exp_new, input logic exp_done);
    int waited = 0;
    bus.fsm_base_header = hdr;
    bus.fsm_data        = data;
    bus.fsm_v           = 1'b1;
    @(negedge clk);
    while (!bus.fsm_ready_and && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, ".rdy"}, 64'(bus.fsm_ready_and), 64'd1);
    chk({tag, ".addr"}, 64'(bus.fsm_addr), 64'(exp_addr));
    chk({tag, ".new"}, 64'(bus.fsm_new), 64'(exp_new));
    chk({tag, ".done"}, 64'(bus.fsm_done), 64'(exp_done));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int waited = 0;
    bus.fsm_v = 1'b0;
    @(negedge clk);
    while (bus.mem_v && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, ".drain"}, 64'(bus.mem_v), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cap(input string tag, input bp_bedrock_mem_header_s hdr0,
                           input bp_bedrock_mem_header_s hdr, input int n,
                           input logic [63:0] base, input logic [15:0] last_mask);
    chk({tag, ".count"}, 64'(cap_q.size()), 64'(n));
    for (int i = 0; i < n && i < cap_q.size(); i++) begin
      chk($sformatf("%s.data%0d", tag, i), cap_q[i].data, base + 64'(i));
      chk($sformatf("%s.last%0d", tag, i), 64'(cap_q[i].last), 64'(last_mask[i]));
      chk($sformatf("%s.hdr%0d", tag, i), 64'(cap_q[i].header), 64'((i == 0) ? hdr0 : hdr));
    end
    cap_q.delete();
  endtask

  bp_bedrock_mem_header_s h, h8, junk;
  logic [39:0] tbl64 [8];
  logic [39:0] tbl32 [4];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.fsm_base_header = '0;
    bus.fsm_data        = '0;
    bus.fsm_v           = 1'b0;
    bus.mem_ready_and   = 1'b1;
    junk = mk_hdr(e_rd_msg, e_size_8, 40'hd_ead0);

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst.mem_v", 64'(bus.mem_v), 64'd0);
    chk("rst.mem_last", 64'(bus.mem_last), 64'd0);
    chk("rst.rdy", 64'(bus.fsm_ready_and), 64'd0);
    chk("rst.new", 64'(bus.fsm_new), 64'd0);
    chk("rst.done", 64'(bus.fsm_done), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst.rdy", 64'(bus.fsm_ready_and), 64'd1);
    @(posedge clk);
    #1;

    // 64B write at 0x8010: wraps after 0x8038; header input scrambled after beat 1
    tbl64 = '{40'h8010, 40'h8018, 40'h8020, 40'h8028, 40'h8030, 40'h8038, 40'h8000, 40'h8008};
    h = mk_hdr(e_wr_msg, e_size_64, 40'h8010);
    for (int i = 0; i < 8; i++)
      send($sformatf("w64.b%0d", i), (i == 0) ? h : junk, 64'h100 + 64'(i), tbl64[i],
           i == 0, i == 7);
    drain("w64");
    check_cap("w64", h, h, 8, 64'h100, 16'h0080);

    // 32B write at 0x8030
    tbl32 = '{40'h8030, 40'h8038, 40'h8020, 40'h8028};
    h = mk_hdr(e_wr_msg, e_size_32, 40'h8030);
    for (int i = 0; i < 4; i++)
      send($sformatf("w32.b%0d", i), (i == 0) ? h : junk, 64'h200 + 64'(i), tbl32[i],
           i == 0, i == 3);
    drain("w32");
    check_cap("w32", h, h, 4, 64'h200, 16'h0008);

    // 64B read: not a payload type, single beat, and 1-cycle latency to mem_v
    h = mk_hdr(e_rd_msg, e_size_64, 40'h8000);
    send("rd64", h, 64'h300, 40'h8000, 1'b1, 1'b1);
    bus.fsm_v = 1'b0;
    @(negedge clk);
    chk("rd64.lat_v", 64'(bus.mem_v), 64'd1);
    chk("rd64.lat_last", 64'(bus.mem_last), 64'd1);
    @(posedge clk);
    #1;
    drain("rd64");
    check_cap("rd64", h, h, 1, 64'h300, 16'h0001);

    // 8B write then back-to-back 64B write at 0x8020 (first_cnt 4)
    h8 = mk_hdr(e_wr_msg, e_size_8, 40'h8018);
    h  = mk_hdr(e_wr_msg, e_size_64, 40'h8020);
    send("w8", h8, 64'h400, 40'h8018, 1'b1, 1'b1);
    tbl64 = '{40'h8020, 40'h8028, 40'h8030, 40'h8038, 40'h8000, 40'h8008, 40'h8010, 40'h8018};
    for (int i = 0; i < 8; i++)
      send($sformatf("b2b.b%0d", i), (i == 0) ? h : junk, 64'h401 + 64'(i), tbl64[i],
           i == 0, i == 7);
    drain("b2b");
    check_cap("b2b", h8, h, 9, 64'h400, 16'h0101);

    // 64B write at 0x8000, bus stalls 3 cycles after beat 2
    h = mk_hdr(e_wr_msg, e_size_64, 40'h8000);
    send("bp.b0", h, 64'h500, 40'h8000, 1'b1, 1'b0);
    send("bp.b1", junk, 64'h501, 40'h8008, 1'b0, 1'b0);
    bus.mem_ready_and = 1'b0;
    send("bp.b2", junk, 64'h502, 40'h8010, 1'b0, 1'b0);
    bus.fsm_data = 64'h503;
    @(negedge clk);
    chk("bp.stall0", 64'(bus.fsm_ready_and), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp.stall1", 64'(bus.fsm_ready_and), 64'd0);
    chk("bp.hold_addr", 64'(bus.fsm_addr), 64'h8018);
    chk("bp.hold_done", 64'(bus.fsm_done), 64'd0);
    @(posedge clk);
    #1;
    bus.mem_ready_and = 1'b1;
    for (int i = 3; i < 8; i++)
      send($sformatf("bp.b%0d", i), junk, 64'h500 + 64'(i), 40'h8000 + 40'(i * 8), 1'b0, i == 7);
    drain("bp");
    check_cap("bp", h, h, 8, 64'h500, 16'h0080);

    // Reset after beat 3 of a 64B write, then a 32B write at 0x8010
    h = mk_hdr(e_wr_msg, e_size_64, 40'h8000);
    send("rs.b0", h, 64'h600, 40'h8000, 1'b1, 1'b0);
    send("rs.b1", junk, 64'h601, 40'h8008, 1'b0, 1'b0);
    send("rs.b2", junk, 64'h602, 40'h8010, 1'b0, 1'b0);
    bus.fsm_v = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rs.rdy_in_reset", 64'(bus.fsm_ready_and), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rs.mem_v", 64'(bus.mem_v), 64'd0);
    chk("rs.mem_last", 64'(bus.mem_last), 64'd0);
    @(posedge clk);
    #1;
    check_cap("rs.partial", h, h, 2, 64'h600, 16'h0000);
    h = mk_hdr(e_wr_msg, e_size_32, 40'h8010);
    tbl32 = '{40'h8010, 40'h8018, 40'h8000, 40'h8008};
    for (int i = 0; i < 4; i++)
      send($sformatf("rs32.b%0d", i), (i == 0) ? h : junk, 64'h700 + 64'(i), tbl32[i],
           i == 0, i == 3);
    drain("rs32");
    check_cap("rs32", h, h, 4, 64'h700, 16'h0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
